// File: rtl/rank_burst_tx.sv
// Burst write driver for one rank: queues write bursts and drives DQ plus a differential
// DQS strobe with programmable pre/postamble. Queued bursts are sent back-to-back without gaps.
module rank_burst_tx #(
  parameter int DQ_W       = 8,
  parameter int BL         = 4,
  parameter int PRE_CYC    = 1,
  parameter int POST_CYC   = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DQ_W*BL-1:0]            in_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  inout  logic [DQ_W-1:0]               dq,
  inout  logic                          dqs_p,
  inout  logic                          dqs_n
);

  localparam int PAY_W = DQ_W * BL;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int BW    = $clog2(BL);

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     beat_nxt;
  logic [PAY_W-1:0]  burst_q;
  logic [DQ_W-1:0]   dq_q;
  logic              dq_oe;
  logic              dqs_oe;
  logic              dqs_p_q;
  logic              dqs_n_q;

  logic [PAY_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              last_beat;
  logic [PAY_W-1:0]  head;

  assign fifo_empty = (level == '0);
  assign in_ready   = (level != LW'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign last_beat  = (beat == BW'(BL - 1));
  assign beat_nxt   = beat + 1'b1;
  assign head       = mem[rd_ptr];
  // Pops happen when leaving IDLE or at the end of a burst, whenever a burst is queued.
  assign pop        = !fifo_empty && ((state == IDLE) || (state == DATA && last_beat));

  assign busy       = (state != IDLE) || !fifo_empty;
  assign fifo_level = level;

  assign dq    = dq_oe  ? dq_q    : {DQ_W{1'bz}};
  assign dqs_p = dqs_oe ? dqs_p_q : 1'bz;
  assign dqs_n = dqs_oe ? dqs_n_q : 1'bz;

  // NOTE: payload storage has no reset; level/pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      beat    <= '0;
      burst_q <= '0;
      dq_q    <= '0;
      dq_oe   <= 1'b0;
      dqs_oe  <= 1'b0;
      dqs_p_q <= 1'b0;
      dqs_n_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          dq_oe  <= 1'b0;
          dqs_oe <= 1'b0;
          if (!fifo_empty) begin
            burst_q <= head;
            cnt     <= '0;
            beat    <= '0;
            dqs_oe  <= 1'b1;
            if (PRE_CYC > 0) begin
              state   <= PRE;
              dqs_p_q <= 1'b0;
              dqs_n_q <= 1'b1;
            end else begin
              state   <= DATA;
              dq_q    <= head[DQ_W-1:0];
              dq_oe   <= 1'b1;
              dqs_p_q <= 1'b1;
              dqs_n_q <= 1'b0;
            end
          end
        end

        PRE: begin
          if (cnt == 3'(PRE_CYC - 1)) begin
            state   <= DATA;
            cnt     <= '0;
            beat    <= '0;
            dq_q    <= burst_q[DQ_W-1:0];
            dq_oe   <= 1'b1;
            dqs_p_q <= 1'b1;
            dqs_n_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (!last_beat) begin
            beat    <= beat_nxt;
            dq_q    <= burst_q[int'(beat_nxt)*DQ_W +: DQ_W];
            dqs_p_q <= beat[0];
            dqs_n_q <= ~beat[0];
            done    <= (beat_nxt == BW'(BL - 1));
          end else if (!fifo_empty) begin
            // Seamless continuation: strobe keeps alternating into beat 0 of the next burst.
            burst_q <= head;
            beat    <= '0;
            dq_q    <= head[DQ_W-1:0];
            dqs_p_q <= 1'b1;
            dqs_n_q <= 1'b0;
          end else if (POST_CYC > 0) begin
            state   <= POST;
            cnt     <= '0;
            beat    <= '0;
            dq_oe   <= 1'b0;
            dqs_p_q <= 1'b0;
            dqs_n_q <= 1'b1;
          end else begin
            state  <= IDLE;
            cnt    <= '0;
            beat   <= '0;
            dq_oe  <= 1'b0;
            dqs_oe <= 1'b0;
          end
        end

        POST: begin
          if (cnt == 3'(POST_CYC - 1)) begin
            state  <= IDLE;
            cnt    <= '0;
            dqs_oe <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rank_burst_tx.sv
// Directed bench for rank_burst_tx: default, zero pre/postamble, and wide/long-burst instances.
// Board pulls (dq/dqs_p high, dqs_n low) make released pins observable.
module tb_rank_burst_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done;
  logic [1:0]  fifo_level;
  tri1  [7:0]  dq;
  tri1         dqs_p;
  tri0         dqs_n;

  // PRE_CYC = 0, POST_CYC = 0
  logic        f_valid;
  logic [31:0] f_data;
  logic        f_ready, f_busy, f_done;
  logic [1:0]  f_level;
  tri1  [7:0]  f_dq;
  tri1         f_dqs_p;
  tri0         f_dqs_n;

  // PRE_CYC = 3, DQ_W = 16, BL = 8
  logic         w_valid;
  logic [127:0] w_data;
  logic         w_ready, w_busy, w_done;
  logic [1:0]   w_level;
  tri1  [15:0]  w_dq;
  tri1          w_dqs_p;
  tri0          w_dqs_n;

  rank_burst_tx u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .fifo_level(fifo_level), .dq(dq), .dqs_p(dqs_p), .dqs_n(dqs_n)
  );

  rank_burst_tx #(.PRE_CYC(0), .POST_CYC(0)) u_fast (
    .clk(clk), .rst(rst), .in_valid(f_valid), .in_ready(f_ready), .in_data(f_data),
    .busy(f_busy), .done(f_done), .fifo_level(f_level), .dq(f_dq), .dqs_p(f_dqs_p), .dqs_n(f_dqs_n)
  );

  rank_burst_tx #(.DQ_W(16), .BL(8), .PRE_CYC(3)) u_wide (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready), .in_data(w_data),
    .busy(w_busy), .done(w_done), .fifo_level(w_level), .dq(w_dq), .dqs_p(w_dqs_p), .dqs_n(w_dqs_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    f_valid = 1'b0; f_data = '0; w_valid = 1'b0; w_data = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_dq", 32'(dq), 32'hff);
    check("rst_dqs_p", 32'(dqs_p), 32'd1);
    check("rst_dqs_n", 32'(dqs_n), 32'd0);
    check("rst_f_ready", 32'(f_ready), 32'd1);
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_w_busy", 32'(w_busy), 32'd0);

    // 1: single burst
    in_valid = 1'b1; in_data = 32'h44332211;
    tick();
    in_valid = 1'b0; in_data = 32'hdeadbeef;
    check("t1_level_q", 32'(fifo_level), 32'd1);
    check("t1_busy_q", 32'(busy), 32'd1);
    check("t1_dqs_idle", 32'(dqs_p), 32'd1);
    tick();
    check("t1_pre_dqs_p", 32'(dqs_p), 32'd0);
    check("t1_pre_dqs_n", 32'(dqs_n), 32'd1);
    check("t1_pre_dq", 32'(dq), 32'hff);
    check("t1_pre_level", 32'(fifo_level), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_dq", 32'(dq), 32'((k + 1) * 'h11));
      check("t1_dqs_p", 32'(dqs_p), 32'((k % 2) == 0));
      check("t1_dqs_n", 32'(dqs_n), 32'((k % 2) == 1));
      check("t1_done", 32'(done), 32'(k == 3));
    end
    tick();
    check("t1_post_dqs_p", 32'(dqs_p), 32'd0);
    check("t1_post_dqs_n", 32'(dqs_n), 32'd1);
    check("t1_post_dq", 32'(dq), 32'hff);
    check("t1_post_done", 32'(done), 32'd0);
    check("t1_post_busy", 32'(busy), 32'd1);
    tick();
    check("t1_idle_dqs_p", 32'(dqs_p), 32'd1);
    check("t1_idle_dqs_n", 32'(dqs_n), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 2: two bursts back-to-back, seamless
    in_valid = 1'b1; in_data = 32'h04030201;
    tick();
    in_data = 32'h08070605;
    tick();
    in_valid = 1'b0;
    check("t2_pre_dqs_p", 32'(dqs_p), 32'd0);
    check("t2_pre_level", 32'(fifo_level), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t2_dq", 32'(dq), 32'(k + 1));
      check("t2_dqs_p", 32'(dqs_p), 32'((k % 2) == 0));
      check("t2_done", 32'(done), 32'(k == 3 || k == 7));
      check("t2_level", 32'(fifo_level), (k < 4) ? 32'd1 : 32'd0);
    end
    tick();
    check("t2_post_dqs_p", 32'(dqs_p), 32'd0);
    check("t2_post_dq", 32'(dq), 32'hff);
    tick();
    check("t2_idle_busy", 32'(busy), 32'd0);

    // 3: in_valid held high; FIFO fills, extra request ignored
    in_valid = 1'b1; in_data = 32'h13121110;
    tick();
    check("t3_level0", 32'(fifo_level), 32'd1);
    check("t3_ready0", 32'(in_ready), 32'd1);
    in_data = 32'h23222120;
    tick();
    check("t3_level1", 32'(fifo_level), 32'd1);
    check("t3_pre", 32'(dqs_p), 32'd0);
    in_data = 32'h33323130;
    tick();
    check("t3_level2", 32'(fifo_level), 32'd2);
    check("t3_ready_full", 32'(in_ready), 32'd0);
    check("t3_dq0", 32'(dq), 32'h10);
    in_data = 32'h99999999;
    tick();
    check("t3_level_hold", 32'(fifo_level), 32'd2);
    check("t3_dq1", 32'(dq), 32'h11);
    tick();
    check("t3_level_hold2", 32'(fifo_level), 32'd2);
    check("t3_ready_hold", 32'(in_ready), 32'd0);
    check("t3_dq2", 32'(dq), 32'h12);
    in_valid = 1'b0;
    for (int j = 3; j < 12; j++) begin
      tick();
      check("t3_dq", 32'(dq), 32'((((j / 4) + 1) << 4) | (j % 4)));
      check("t3_dqs_p", 32'(dqs_p), 32'((j % 2) == 0));
      check("t3_done", 32'(done), 32'((j % 4) == 3));
    end
    tick();
    check("t3_post_dqs_p", 32'(dqs_p), 32'd0);
    tick();
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_idle_level", 32'(fifo_level), 32'd0);

    // 4: reset during beat 2
    in_valid = 1'b1; in_data = 32'h44332211;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_data = 32'h55555555;
    tick();
    in_valid = 1'b0;
    tick();
    check("t4_beat2", 32'(dq), 32'h33);
    check("t4_level_pre", 32'(fifo_level), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_dq", 32'(dq), 32'hff);
    check("t4_rst_dqs_p", 32'(dqs_p), 32'd1);
    check("t4_rst_dqs_n", 32'(dqs_n), 32'd0);
    check("t4_rst_level", 32'(fifo_level), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_ready", 32'(in_ready), 32'd1);
    tick();
    check("t4_after_done", 32'(done), 32'd0);
    check("t4_after_dq", 32'(dq), 32'hff);
    in_valid = 1'b1; in_data = 32'h0d0c0b0a;
    tick();
    in_valid = 1'b0;
    tick();
    check("t4_pre_dqs_p", 32'(dqs_p), 32'd0);
    check("t4_pre_dq", 32'(dq), 32'hff);
    tick();
    check("t4_beat0", 32'(dq), 32'h0a);
    check("t4_beat0_dqs_p", 32'(dqs_p), 32'd1);
    for (int k = 0; k < 5; k++) tick();
    check("t4_end_busy", 32'(busy), 32'd0);

    // 5: no preamble, no postamble
    f_valid = 1'b1; f_data = 32'ha4a3a2a1;
    tick();
    f_valid = 1'b0;
    check("t5_wait_dq", 32'(f_dq), 32'hff);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_dq", 32'(f_dq), 32'('ha1 + k));
      check("t5_dqs_p", 32'(f_dqs_p), 32'((k % 2) == 0));
      check("t5_done", 32'(f_done), 32'(k == 3));
    end
    tick();
    check("t5_rel_dq", 32'(f_dq), 32'hff);
    check("t5_rel_dqs_p", 32'(f_dqs_p), 32'd1);
    check("t5_rel_dqs_n", 32'(f_dqs_n), 32'd0);
    check("t5_rel_busy", 32'(f_busy), 32'd0);
    check("t5_level", 32'(f_level), 32'd0);

    // 6: 3-cycle preamble, 16-bit lanes, 8 beats
    for (int k = 0; k < 8; k++) w_data[k*16 +: 16] = 16'(16'hb0c0 + k * 16'h0101);
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick();
      check("t6_pre_dqs_p", 32'(w_dqs_p), 32'd0);
      check("t6_pre_dqs_n", 32'(w_dqs_n), 32'd1);
      check("t6_pre_dq", 32'(w_dq), 32'hffff);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t6_dq", 32'(w_dq), 32'(16'hb0c0 + k * 16'h0101));
      check("t6_dqs_p", 32'(w_dqs_p), 32'((k % 2) == 0));
      check("t6_done", 32'(w_done), 32'(k == 7));
    end
    tick();
    check("t6_post_dqs_p", 32'(w_dqs_p), 32'd0);
    check("t6_post_dq", 32'(w_dq), 32'hffff);
    tick();
    check("t6_idle_dqs_p", 32'(w_dqs_p), 32'd1);
    check("t6_idle_busy", 32'(w_busy), 32'd0);
    check("t6_level", 32'(w_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
